// File: rtl/uart_receiver.sv
// 8N1 (or 8E1 with UART_RX_PARITY_EN defined) oversampling serial receiver.
// Synchronizes rx, aligns sampling to the start edge, strobes valid/frame_err/parity_err.
module uart_receiver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              rx_q1, rx_s;
  logic [1:0]        fill_q;
  logic              armed_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [OS_W-1:0]   samp_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              valid_q, frame_q;
  logic              par_bad_q;

  logic tick, mid_tick, full_tick, run;
  logic samp_clr, shift_en, par_sample, load_data;
  logic valid_d, frame_d, par_err_d;

  assign tick      = (div_cnt == DIV_W'(DIV - 1));
  assign mid_tick  = tick && (samp_cnt == OS_W'(OVERSAMPLE / 2 - 1));
  assign full_tick = tick && (samp_cnt == OS_W'(OVERSAMPLE - 1));
  // Counters only run inside a frame, so leaving IDLE always starts them from zero.
  assign run = (state_q == S_START) || (state_q == S_DATA) ||
               (state_q == S_PARITY) || (state_q == S_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1   <= 1'b1;
      rx_s    <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      rx_q1   <= rx;
      rx_s    <= rx_q1;
      fill_q  <= {fill_q[0], 1'b1};
      // A line still low from a frame cut off by reset must go high before we listen.
      armed_q <= armed_q | (fill_q[1] & rx_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    samp_clr   = 1'b0;
    shift_en   = 1'b0;
    par_sample = 1'b0;
    load_data  = 1'b0;
    valid_d    = 1'b0;
    frame_d    = 1'b0;
    par_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (armed_q && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (mid_tick) begin
          samp_clr = 1'b1;
          state_d  = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (full_tick) begin
          par_sample = 1'b1;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (full_tick) begin
          load_data = 1'b1;
          par_err_d = par_bad_q;
          if (rx_s) begin
            valid_d = !par_bad_q;
            state_d = S_IDLE;
          end else begin
            frame_d = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
      bit_cnt  <= 3'd0;
    end else if (!run) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
      bit_cnt  <= 3'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (samp_clr) begin
        samp_cnt <= '0;
      end else if (tick) begin
        samp_cnt <= (samp_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt + OS_W'(1);
      end
      if (shift_en) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      frame_q <= frame_d;
      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
      if (load_data) data_q <= shift_q;
      if (state_q == S_IDLE) begin
        par_bad_q <= 1'b0;
      end else if (par_sample) begin
        // Even parity: the parity bit makes the total count of ones even.
        par_bad_q <= ((^shift_q) != rx_s);
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clk/bit (DIV=1); the parity case runs
// only when UART_RX_PARITY_EN is defined for both RTL and bench.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int valid_cyc = 0, start_cyc = 0;
  bit watch_busy = 1'b0, busy_dropped = 1'b0, prev_valid = 1'b0;
  int v0, f0, p0, lat;

  uart_receiver #(
    .CLK_HZ(1_600_000),
    .BAUD(100_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers (all called at a negedge, leave at a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                            input int nbits);
    rx = 1'b0;
    start_cyc = cyc;
    idle(16);
    for (int i = 0; i < nbits; i++) send_bit(b[i]);
    if (nbits >= 8) begin
`ifdef UART_RX_PARITY_EN
      send_bit((^b) ^ par_flip);
`else
      if (par_flip) $display("[TB] parity flip ignored in 8N1 build");
`endif
      send_bit(stop);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        valid_cnt++;
        valid_cyc  = cyc;
        watch_busy = 1'b0;
        if (prev_valid) check("valid_pulse_width", 1, 0);
        if (frame_err || parity_err) check("strobe_overlap", 1, 0);
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("sb_data", data, exp_q.pop_front());
      end
      if (frame_err) ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (watch_busy && !busy) busy_dropped = 1'b1;
    end
    prev_valid = valid;
  end

  initial begin
    logic [7:0] b5a;
    rx  = 1'b1;
    rst = 1'b1;
    idle(5);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    rst = 1'b0;
    idle(5);

    // 1: single byte A5, latency and busy
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    fork
      begin idle(5); watch_busy = 1'b1; end
    join_none
    send_frame(8'hA5, 1'b1, 1'b0, 8);
    idle(20);
    lat = valid_cyc - start_cyc;
    check("t1_valid_count", valid_cnt - v0, 1);
    check("t1_data", data, 8'hA5);
    check("t1_frame_err", ferr_cnt - f0, 0);
    check("t1_latency_in_153_155", (lat >= 153 && lat <= 155), 1);
    check("t1_busy_held", busy_dropped, 0);
    check("t1_busy_idle", busy, 0);

    // 2: back-to-back 00, FF
    v0 = valid_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0, 8);
    send_frame(8'hFF, 1'b1, 1'b0, 8);
    idle(20);
    check("t2_valid_count", valid_cnt - v0, 2);
    check("t2_data", data, 8'hFF);

    // 3: 4-clk glitch
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    check("t3_valid_count", valid_cnt - v0, 0);
    check("t3_frame_err", ferr_cnt - f0, 0);
    check("t3_busy", busy, 0);
    check("t3_state_idle", 32'(dut.state_q), 0);

    // 4: low stop bit, break, then normal byte
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 8);
    idle(24);
    check("t4_busy_in_break", busy, 1);
    rx = 1'b1;
    idle(20);
    check("t4_frame_err_count", ferr_cnt - f0, 1);
    check("t4_valid_count", valid_cnt - v0, 0);
    check("t4_data", data, 8'h3C);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 8);
    idle(20);
    check("t4_next_valid", valid_cnt - v0, 1);
    check("t4_next_data", data, 8'h81);

    // 5: reset mid-frame at bit 4 of 5A
    v0 = valid_cnt; f0 = ferr_cnt;
    b5a = 8'h5A;
    send_frame(b5a, 1'b1, 1'b0, 4);
    rst = 1'b1;
    rx  = b5a[4];
    idle(2);
    check("t5_rst_data", data, 8'h00);
    check("t5_rst_busy", busy, 0);
    idle(14);
    for (int i = 5; i < 8; i++) send_bit(b5a[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b5a);
`endif
    send_bit(1'b1);
    rst = 1'b0;
    idle(10);
    check("t5_no_strobe", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 8);
    idle(20);
    check("t5_valid_count", valid_cnt - v0, 1);
    check("t5_data", data, 8'hC3);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    v0 = valid_cnt; p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 8);
    idle(20);
    check("t6_good_valid", valid_cnt - v0, 1);
    check("t6_good_perr", perr_cnt - p0, 0);
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 8);
    idle(20);
    check("t6_bad_valid", valid_cnt - v0, 0);
    check("t6_bad_perr", perr_cnt - p0, 1);
    check("t6_bad_data", data, 8'h07);
`else
    p0 = perr_cnt;
    check("no_parity_err_8n1", p0, 0);
`endif

    check("sb_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
